// File: rtl/two_port_mem_be.sv
// two_port_mem_be: single-clock simple dual-port RAM with per-byte write enables,
// write-first forwarding, out-of-range detection, 1- or 2-cycle read latency and an
// optional post-reset clear sweep.
module two_port_mem_be #(
    parameter int unsigned           BIT_LENGTH     = 64,
    parameter int unsigned           DEPTH          = 16,
    parameter int unsigned           BYTE_W         = 8,
    parameter int unsigned           READ_LATENCY   = 1,
    parameter string                 MODE           = "block",
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [BIT_LENGTH-1:0] INIT_VALUE     = '0,
    localparam int unsigned          NB             = BIT_LENGTH / BYTE_W,
    localparam int unsigned          AW             = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wea,
    input  logic [AW-1:0]         addra,
    input  logic [BIT_LENGTH-1:0] dina,
    input  logic [NB-1:0]         bea,
    input  logic                  enb,
    input  logic [AW-1:0]         addrb,
    output logic [BIT_LENGTH-1:0] doutb,
    output logic                  validb,
    output logic                  init_busy,
    output logic                  err_addr
);

    // Reject illegal configurations at elaboration time.
    if (BIT_LENGTH % BYTE_W != 0) begin : g_bad_width
        $error("BIT_LENGTH must be a multiple of BYTE_W");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (MODE != "block" && MODE != "distribute" && MODE != "ultra") begin : g_bad_mode
        $error("MODE must be block, distribute or ultra");
    end

    localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    (* ram_style = MODE *) logic [BIT_LENGTH-1:0] mem [DEPTH];

    state_e                state_q;
    logic [AW-1:0]         ptr_q;
    logic                  ready;
    logic                  wr_in, rd_in;
    logic                  wr_en, rd_req;
    logic [BIT_LENGTH-1:0] rd_word;
    logic [BIT_LENGTH-1:0] rd1_data_q;
    logic                  rd1_valid_q;
    logic                  err_q;

    assign ready     = (state_q == StReady);
    assign wr_in     = ({1'b0, addra} < DepthW);
    assign rd_in     = ({1'b0, addrb} < DepthW);
    assign wr_en     = ready && wea && wr_in;
    assign rd_req    = ready && enb;
    assign init_busy = (state_q == StClear);
    assign err_addr  = err_q;

    // Clear/ready sequencer: sweep pointer walks every entry once after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? StClear : StReady;
            ptr_q   <= '0;
        end else if (state_q == StClear) begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == LastAddr) begin
                state_q <= StReady;
            end
        end
    end

    // Storage: sweep writes take priority; normal writes update enabled lanes only.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == StClear) begin
                mem[ptr_q] <= INIT_VALUE;
            end else if (wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (bea[i]) begin
                        mem[addra][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // Read word with write-first forwarding; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = mem[addrb];
            if (wr_en && (addra == addrb)) begin
                for (int i = 0; i < NB; i++) begin
                    if (bea[i]) begin
                        rd_word[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // First read stage plus sticky address-error flag; data holds when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd1_valid_q <= 1'b0;
            rd1_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rd1_valid_q <= rd_req;
            if (rd_req) begin
                rd1_data_q <= rd_word;
            end
            if (ready && ((wea && !wr_in) || (enb && !rd_in))) begin
                err_q <= 1'b1;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [BIT_LENGTH-1:0] rd2_data_q;
        logic                  rd2_valid_q;

        // Extra output register carrying both data and valid.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd2_valid_q <= 1'b0;
                rd2_data_q  <= '0;
            end else begin
                rd2_valid_q <= rd1_valid_q;
                if (rd1_valid_q) begin
                    rd2_data_q <= rd1_data_q;
                end
            end
        end

        assign doutb  = rd2_data_q;
        assign validb = rd2_valid_q;
    end else begin : g_lat1
        assign doutb  = rd1_data_q;
        assign validb = rd1_valid_q;
    end

endmodule
